cache_port_arbiter: RTL

// Shares the single Cache requester port (address/data_in/write_enable in; data_out/data_out_ready/busy out)

---
 rtl/cache_port_arbiter_pkg.sv | 17 +
 rtl/cache_port_arbiter_if.sv | 22 ++
 rtl/cache_port_arbiter_rr_arbiter2.sv | 24 ++
 rtl/cache_port_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cache_port_arbiter_pkg.sv
// Shared types for the two-port cache arbiter: FSM states, port index and
// the write-strobe encoding that means "read".
package cache_port_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE,
        WAIT,
        ACK
    } state_t;

    typedef logic port_ix_t;

    localparam logic [3:0] WE_READ = 4'b0000;

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Requester-side bundle: one instance per core-side master. The master
// holds req with stable operands until it sees the one-cycle ack.
interface cache_port_arbiter_if;

    logic        req;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [3:0]  write_enable;
    logic        ack;
    logic [31:0] data_out;

    modport master (
        output req, address, data_in, write_enable,
        input  ack, data_out
    );

    modport slave (
        input  req, address, data_in, write_enable,
        output ack, data_out
    );

endinterface

// File: rtl/cache_port_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to
// the port that did not win the previous transaction.
module rr_arbiter2
    import cache_port_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  port_ix_t   last_grant_i,
    output port_ix_t   winner_o,
    output logic       any_o
);

    // Winner select; the idle default of port 0 is harmless because any_o gates its use.
    always_comb begin
        winner_o = 1'b0;
        if (req_i == 2'b11) begin
            winner_o = ~last_grant_i;
        end else if (req_i[1]) begin
            winner_o = 1'b1;
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cache requester port between two masters. Each transaction is
// sequenced IDLE -> ISSUE -> SETTLE -> WAIT -> ACK, with an optional
// watchdog that aborts a stuck transaction and raises a sticky err.
module cache_port_arbiter
    import cache_port_arbiter_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    cache_port_arbiter_if.slave        p0_if,
    cache_port_arbiter_if.slave        p1_if,
    output logic [31:0]                c_address_o,
    output logic [31:0]                c_data_in_o,
    output logic [3:0]                 c_write_enable_o,
    input  logic [31:0]                c_data_out_i,
    input  logic                       c_data_out_ready_i,
    input  logic                       c_busy_i,
    output port_ix_t                   grant_o,
    output logic                       active_o,
    output logic                       err_o
);

    localparam int unsigned SW = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TOUT_LAST   = TW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    port_ix_t      grant_q, grant_d;
    port_ix_t      last_grant_q, last_grant_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    we_q, we_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [TW-1:0] tout_q, tout_d;
    logic          err_q, err_d;
    logic [31:0]   rdata0_q, rdata0_d;
    logic [31:0]   rdata1_q, rdata1_d;

    port_ix_t      winner;
    logic          any_req;
    logic          is_read;
    logic          tout_hit;

    rr_arbiter2 u_rr (
        .req_i        ({p1_if.req, p0_if.req}),
        .last_grant_i (last_grant_q),
        .winner_o     (winner),
        .any_o        (any_req)
    );

    assign is_read  = (we_q == WE_READ);
    assign tout_hit = (TIMEOUT_CYCLES != 0) && (tout_q == TOUT_LAST);

    // Next-state, operand latching, counters and read-data capture.
    always_comb begin
        // NOTE: every _d starts from its _q so no branch leaves a variable unassigned, which would infer a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        settle_d     = settle_q;
        tout_d       = tout_q;
        err_d        = err_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    addr_d  = winner ? p1_if.address      : p0_if.address;
                    wdata_d = winner ? p1_if.data_in      : p0_if.data_in;
                    we_d    = winner ? p1_if.write_enable : p0_if.write_enable;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                settle_d = '0;
                tout_d   = '0;
                state_d  = SETTLE;
            end
            SETTLE: begin
                // Cache status is untrusted here, so ready/busy are deliberately ignored.
                tout_d = tout_q + 1'b1;
                if (tout_hit) begin
                    err_d   = 1'b1;
                    state_d = ACK;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = WAIT;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            WAIT: begin
                tout_d = tout_q + 1'b1;
                if (is_read && c_data_out_ready_i) begin
                    if (grant_q) rdata1_d = c_data_out_i;
                    else         rdata0_d = c_data_out_i;
                    state_d = ACK;
                end else if (!is_read && !c_busy_i) begin
                    state_d = ACK;
                end else if (tout_hit) begin
                    err_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples the pre-edge values.
        if (rst) begin
            // NOTE: operand and read-data registers are reset too, because every output must read 0 after rst.
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= WE_READ;
            settle_q     <= '0;
            tout_q       <= '0;
            err_q        <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            settle_q     <= settle_d;
            tout_q       <= tout_d;
            err_q        <= err_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Address/data hold their last value between transactions; the strobe exists only in ISSUE.
    assign c_address_o      = addr_q;
    assign c_data_in_o      = wdata_q;
    assign c_write_enable_o = (state_q == ISSUE) ? we_q : WE_READ;
    assign grant_o          = grant_q;
    assign active_o         = (state_q != IDLE);
    assign err_o            = err_q;

    assign p0_if.ack      = (state_q == ACK) && (grant_q == 1'b0);
    assign p1_if.ack      = (state_q == ACK) && (grant_q == 1'b1);
    assign p0_if.data_out = rdata0_q;
    assign p1_if.data_out = rdata1_q;

endmodule
